// File: rtl/axis_pack_pkg.sv
// Shared constants and types for the 16-to-32 AXI-Stream packer.
package axis_pack_pkg;

   localparam logic [3:0] KEEP_FULL = 4'b1111;
   localparam logic [3:0] KEEP_LO   = 4'b0011;

   typedef enum logic {LO, HI} phase_e;

endpackage

// File: rtl/axis_pack_16to32_if.sv
// Generic AXI-Stream bundle; tkeep carries one bit per byte lane.
interface axi_stream_inf #(
   parameter int unsigned DSIZE = 16
);

   localparam int unsigned KSIZE = (DSIZE / 8 > 0) ? DSIZE / 8 : 1;

   logic             axis_tvalid;
   logic             axis_tready;
   logic [DSIZE-1:0] axis_tdata;
   logic             axis_tlast;
   logic [KSIZE-1:0] axis_tkeep;

   modport master (
      output axis_tvalid,
      output axis_tdata,
      output axis_tlast,
      output axis_tkeep,
      input  axis_tready
   );

   modport slave (
      input  axis_tvalid,
      input  axis_tdata,
      input  axis_tlast,
      input  axis_tkeep,
      output axis_tready
   );

endinterface

// File: rtl/axis_out_reg.sv
// Single-entry output holding register with valid/ready; contents stay stable while stalled.
module axis_out_reg #(
   parameter int unsigned DW = 32,
   parameter int unsigned KW = 4
) (
   input  logic          clock,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic [KW-1:0] load_keep,
   input  logic          load_last,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic [KW-1:0] out_keep,
   output logic          out_last,
   output logic          stall
);

   assign stall = out_valid && !out_ready;

   // Callers only load when not stalled, so a load always overwrites a consumed or empty slot.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_keep  <= load_keep;
         out_last  <= load_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/axis_pack_16to32.sv
// Packs pairs of 16-bit stream beats into 32-bit beats; odd frame tails go out half-filled.
module axis_pack_16to32
   import axis_pack_pkg::*;
#(
   parameter int unsigned IDSIZE = 16,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clock,
   input  logic             rst_n,
   axi_stream_inf.slave     origin_inf,
   axi_stream_inf.master    wide_inf,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] odd_cnt
);

   localparam int unsigned ODSIZE = 2 * IDSIZE;

   phase_e              phase;
   logic [IDSIZE-1:0]   half;
   logic                out_stall;
   logic                accept;
   logic                load;
   logic [ODSIZE-1:0]   load_data;
   logic [3:0]          load_keep;

   assign origin_inf.axis_tready = !out_stall;
   assign accept = origin_inf.axis_tvalid && !out_stall;
   assign load   = accept && ((phase == HI) || origin_inf.axis_tlast);

   // First beat of a pair lands in the low lanes.
   always_comb begin
      load_data = {{IDSIZE{1'b0}}, origin_inf.axis_tdata};
      load_keep = KEEP_LO;
      if (phase == HI) begin
         load_data = {origin_inf.axis_tdata, half};
         load_keep = KEEP_FULL;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         phase     <= LO;
         half      <= '0;
         frame_cnt <= '0;
         odd_cnt   <= '0;
      end else if (accept) begin
         if (phase == LO) begin
            if (origin_inf.axis_tlast) begin
               frame_cnt <= frame_cnt + 1'b1;
               odd_cnt   <= odd_cnt + 1'b1;
            end else begin
               half  <= origin_inf.axis_tdata;
               phase <= HI;
            end
         end else begin
            phase <= LO;
            if (origin_inf.axis_tlast) begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

   axis_out_reg #(
      .DW(ODSIZE),
      .KW(4)
   ) u_out_reg (
      .clock     (clock),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (load_data),
      .load_keep (load_keep),
      .load_last (origin_inf.axis_tlast),
      .out_ready (wide_inf.axis_tready),
      .out_valid (wide_inf.axis_tvalid),
      .out_data  (wide_inf.axis_tdata),
      .out_keep  (wide_inf.axis_tkeep),
      .out_last  (wide_inf.axis_tlast),
      .stall     (out_stall)
   );

endmodule

// File: tb/tb_axis_pack_16to32.sv
// Directed bench for axis_pack_16to32: packing, odd tails, backpressure, async reset, counter wrap.
module tb_axis_pack_16to32;
   import axis_pack_pkg::*;

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] frame_cnt;
   logic [15:0] odd_cnt;
   int          checks = 0;
   int          failures = 0;
   logic [36:0] got_q[$];   // {last, keep, data}

   always #5 clock = ~clock;

   axi_stream_inf #(.DSIZE(16)) origin ();
   axi_stream_inf #(.DSIZE(32)) wide ();

   axis_pack_16to32 dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .origin_inf (origin),
      .wide_inf   (wide),
      .frame_cnt  (frame_cnt),
      .odd_cnt    (odd_cnt)
   );

   always @(posedge clock) begin
      if (rst_n && wide.axis_tvalid && wide.axis_tready)
         got_q.push_back({wide.axis_tlast, wide.axis_tkeep, wide.axis_tdata});
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      origin.axis_tvalid = 1'b0;
      origin.axis_tdata  = '0;
      origin.axis_tlast  = 1'b0;
      origin.axis_tkeep  = 2'b11;
      wide.axis_tready   = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      @(negedge clock);
      got_q.delete();
   endtask

   // Entered and left on a negedge; holds the beat until the handshake edge.
   task automatic send_beat(input logic [15:0] d, input logic last);
      int n = 0;
      origin.axis_tvalid = 1'b1;
      origin.axis_tdata  = d;
      origin.axis_tlast  = last;
      while (!origin.axis_tready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!origin.axis_tready) begin
         checks++; failures++;
         $display("FAIL send_timeout: origin tready=%0b after %0d cycles, required 1", origin.axis_tready, n);
      end
      @(posedge clock);
      @(negedge clock);
      origin.axis_tvalid = 1'b0;
      origin.axis_tlast  = 1'b0;
   endtask

   task automatic wait_beats(input int n);
      int c = 0;
      while (got_q.size() < n && c < 400) begin
         @(negedge clock);
         c++;
      end
      checks++;
      if (got_q.size() != n) begin
         failures++;
         $display("FAIL beat_count: got %0d output beats, required %0d", got_q.size(), n);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({wide.axis_tvalid, wide.axis_tlast, wide.axis_tkeep} !== 6'b0 || wide.axis_tdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_out: valid=%0b last=%0b keep=%h data=%h, required all 0",
                  wide.axis_tvalid, wide.axis_tlast, wide.axis_tkeep, wide.axis_tdata);
      end
      checks++;
      if (frame_cnt !== 16'h0 || odd_cnt !== 16'h0) begin
         failures++;
         $display("FAIL reset_cnt: frame=%h odd=%h, required 0 0", frame_cnt, odd_cnt);
      end
      checks++;
      if (origin.axis_tready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: origin tready=%0b, required 1", origin.axis_tready);
      end
   endtask

   task automatic test_even_frame();
      apply_reset();
      send_beat(16'h1111, 1'b0);
      send_beat(16'h2222, 1'b0);
      send_beat(16'h3333, 1'b0);
      send_beat(16'h4444, 1'b1);
      wait_beats(2);
      checks++;
      if (got_q[0] !== {1'b0, KEEP_FULL, 32'h22221111}) begin
         failures++;
         $display("FAIL even_beat0: got %h, required %h", got_q[0], {1'b0, KEEP_FULL, 32'h22221111});
      end
      checks++;
      if (got_q[1] !== {1'b1, KEEP_FULL, 32'h44443333}) begin
         failures++;
         $display("FAIL even_beat1: got %h, required %h", got_q[1], {1'b1, KEEP_FULL, 32'h44443333});
      end
      checks++;
      if (frame_cnt !== 16'd1 || odd_cnt !== 16'd0) begin
         failures++;
         $display("FAIL even_cnt: frame=%0d odd=%0d, required 1 0", frame_cnt, odd_cnt);
      end
   endtask

   task automatic test_odd_tail();
      apply_reset();
      send_beat(16'hAAAA, 1'b0);
      send_beat(16'hBBBB, 1'b0);
      send_beat(16'hCCCC, 1'b1);
      wait_beats(2);
      checks++;
      if (got_q[0] !== {1'b0, KEEP_FULL, 32'hBBBBAAAA}) begin
         failures++;
         $display("FAIL odd_beat0: got %h, required %h", got_q[0], {1'b0, KEEP_FULL, 32'hBBBBAAAA});
      end
      checks++;
      if (got_q[1] !== {1'b1, KEEP_LO, 32'h0000CCCC}) begin
         failures++;
         $display("FAIL odd_beat1: got %h, required %h", got_q[1], {1'b1, KEEP_LO, 32'h0000CCCC});
      end
      checks++;
      if (frame_cnt !== 16'd1 || odd_cnt !== 16'd1) begin
         failures++;
         $display("FAIL odd_cnt: frame=%0d odd=%0d, required 1 1", frame_cnt, odd_cnt);
      end
   endtask

   task automatic test_single_beat();
      apply_reset();
      send_beat(16'h5A5A, 1'b1);
      // One cycle after the handshake edge the beat must already be presented.
      checks++;
      if (wide.axis_tvalid !== 1'b1 || wide.axis_tdata !== 32'h00005A5A ||
          wide.axis_tkeep !== KEEP_LO || wide.axis_tlast !== 1'b1) begin
         failures++;
         $display("FAIL single_beat: valid=%0b data=%h keep=%h last=%0b, required 1 00005a5a 3 1",
                  wide.axis_tvalid, wide.axis_tdata, wide.axis_tkeep, wide.axis_tlast);
      end
      checks++;
      if (frame_cnt !== 16'd1 || odd_cnt !== 16'd1) begin
         failures++;
         $display("FAIL single_cnt: frame=%0d odd=%0d, required 1 1", frame_cnt, odd_cnt);
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      wide.axis_tready = 1'b0;
      send_beat(16'h1111, 1'b0);
      send_beat(16'h2222, 1'b0);
      origin.axis_tvalid = 1'b1;
      origin.axis_tdata  = 16'h3333;
      origin.axis_tlast  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (origin.axis_tready !== 1'b0 || wide.axis_tvalid !== 1'b1 ||
             wide.axis_tdata !== 32'h22221111) begin
            failures++;
            $display("FAIL stall_hold cycle %0d: ready=%0b valid=%0b data=%h, required 0 1 22221111",
                     i, origin.axis_tready, wide.axis_tvalid, wide.axis_tdata);
         end
         @(negedge clock);
      end
      wide.axis_tready = 1'b1;
      send_beat(16'h3333, 1'b1);
      wait_beats(2);
      checks++;
      if (got_q[0] !== {1'b0, KEEP_FULL, 32'h22221111} || got_q[1] !== {1'b1, KEEP_LO, 32'h00003333}) begin
         failures++;
         $display("FAIL stall_release: got %h %h, required %h %h", got_q[0], got_q[1],
                  {1'b0, KEEP_FULL, 32'h22221111}, {1'b1, KEEP_LO, 32'h00003333});
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] beats[$];
      logic        lasts[$];
      logic [36:0] exp_q[$];
      logic [15:0] m_half = '0;
      logic        m_hi = 1'b0;
      int          m_frames = 0;
      int          m_odd = 0;
      int          remaining = 100;
      bit          done = 1'b0;
      apply_reset();
      while (remaining > 0) begin
         int len = $urandom_range(1, 7);
         if (len > remaining) len = remaining;
         for (int i = 0; i < len; i++) begin
            logic [15:0] d = 16'($urandom);
            logic        l = (i == len - 1);
            beats.push_back(d);
            lasts.push_back(l);
            if (!m_hi) begin
               if (l) begin
                  exp_q.push_back({1'b1, KEEP_LO, 16'h0, d});
                  m_frames++; m_odd++;
               end else begin
                  m_half = d; m_hi = 1'b1;
               end
            end else begin
               exp_q.push_back({l, KEEP_FULL, d, m_half});
               if (l) m_frames++;
               m_hi = 1'b0;
            end
         end
         remaining -= len;
      end
      fork
         begin
            for (int i = 0; i < beats.size(); i++) send_beat(beats[i], lasts[i]);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clock);
               #1 wide.axis_tready = ($urandom_range(0, 3) != 0);
            end
            wide.axis_tready = 1'b1;
         end
      join
      wait_beats(exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL stream_beat %0d: got %h, required %h", i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (frame_cnt !== 16'(m_frames) || odd_cnt !== 16'(m_odd)) begin
         failures++;
         $display("FAIL stream_cnt: frame=%0d odd=%0d, required %0d %0d", frame_cnt, odd_cnt, m_frames, m_odd);
      end
   endtask

   task automatic test_reset_midframe();
      apply_reset();
      wide.axis_tready = 1'b0;
      send_beat(16'hAAAA, 1'b0);
      send_beat(16'hBBBB, 1'b1);
      checks++;
      if (wide.axis_tvalid !== 1'b1 || frame_cnt !== 16'd1) begin
         failures++;
         $display("FAIL pre_reset: valid=%0b frame=%0d, required 1 1", wide.axis_tvalid, frame_cnt);
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (wide.axis_tvalid !== 1'b0 || wide.axis_tkeep !== 4'h0 || frame_cnt !== 16'd0 || odd_cnt !== 16'd0) begin
         failures++;
         $display("FAIL async_reset: valid=%0b keep=%h frame=%0d odd=%0d, required 0 0 0 0",
                  wide.axis_tvalid, wide.axis_tkeep, frame_cnt, odd_cnt);
      end
      @(negedge clock);
      rst_n = 1'b1;
      wide.axis_tready = 1'b1;
      @(negedge clock);
      // Leave a dangling low half, then reset it away.
      send_beat(16'h7777, 1'b0);
      #3 rst_n = 1'b0;
      @(negedge clock);
      rst_n = 1'b1;
      @(negedge clock);
      got_q.delete();
      send_beat(16'h0001, 1'b0);
      send_beat(16'h0002, 1'b1);
      wait_beats(1);
      checks++;
      if (got_q[0] !== {1'b1, KEEP_FULL, 32'h00020001}) begin
         failures++;
         $display("FAIL post_reset: got %h, required %h", got_q[0], {1'b1, KEEP_FULL, 32'h00020001});
      end
   endtask

   task automatic test_counter_wrap();
      apply_reset();
      for (int i = 0; i < 65535; i++) send_beat(16'(i), 1'b1);
      got_q.delete();
      checks++;
      if (frame_cnt !== 16'hFFFF || odd_cnt !== 16'hFFFF) begin
         failures++;
         $display("FAIL cnt_allones: frame=%h odd=%h, required ffff ffff", frame_cnt, odd_cnt);
      end
      send_beat(16'hFFFF, 1'b1);
      checks++;
      if (frame_cnt !== 16'h0 || odd_cnt !== 16'h0) begin
         failures++;
         $display("FAIL cnt_wrap: frame=%h odd=%h, required 0 0", frame_cnt, odd_cnt);
      end
      got_q.delete();
   endtask

   initial begin
      test_reset();
      test_even_frame();
      test_odd_tail();
      test_single_beat();
      test_backpressure();
      test_back_to_back();
      test_reset_midframe();
      test_counter_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
